// File: rtl/imem_responder.sv
// imem_responder: instruction memory that is first filled by a valid/ready
// load stream (words to consecutive addresses from 0), then serves fetch reads
// with one cycle of registered latency.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_imem_addr       fetch word address (PC)
//   o_imem_rdata      registered read data (NOP_WORD when masked/out of range)
//   o_imem_ready      1 in RUN phase
//   i_ld_valid/data/last, o_ld_ready   program-image load stream
//   o_ld_count        words written since reset
//   o_ld_err          sticky: memory filled before last word was seen
module imem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [31:0]           i_imem_addr,
    output logic [31:0]           o_imem_rdata,
    output logic                  o_imem_ready,
    input  logic                  i_ld_valid,
    input  logic [31:0]           i_ld_data,
    input  logic                  i_ld_last,
    output logic                  o_ld_ready,
    output logic [DEPTH_LOG2:0]   o_ld_count,
    output logic                  o_ld_err
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2-1:0] WPTR_MAX = DEPTH_LOG2'(DEPTH - 1);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  ld_ready_q;
    logic                  imem_ready_q;
    logic [31:0]           rdata_q;
    logic                  mem_we;
    logic                  rd_en;

    logic [31:0] mem [DEPTH];

    // Next-state and load-side control.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (i_ld_valid) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    // Pointer saturates at the top so it never wraps.
                    if (wptr_q != WPTR_MAX) begin
                        wptr_d = wptr_q + DEPTH_LOG2'(1);
                    end
                    if (i_ld_last) begin
                        state_d = ST_RUN;
                    end else if (wptr_q == WPTR_MAX) begin
                        state_d = ST_RUN;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and status registers; handshake flags track the next state so
    // they are pure register outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_LOAD;
            wptr_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            ld_ready_q   <= 1'b1;
            imem_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            ld_ready_q   <= (state_d == ST_LOAD);
            imem_ready_q <= (state_d == ST_RUN);
        end
    end

    // Storage write port; contents are not cleared by reset.
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_rst) begin
            mem[wptr_q] <= i_ld_data;
        end
    end

    // Reads are only live in RUN with the upper address bits clear.
    assign rd_en = (state_q == ST_RUN) && ((i_imem_addr >> DEPTH_LOG2) == 32'd0);

    // Synchronous read port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q <= NOP_WORD;
        end else if (rd_en) begin
            rdata_q <= mem[i_imem_addr[DEPTH_LOG2-1:0]];
        end else begin
            rdata_q <= NOP_WORD;
        end
    end

    assign o_imem_rdata = rdata_q;
    assign o_imem_ready = imem_ready_q;
    assign o_ld_ready   = ld_ready_q;
    assign o_ld_count   = cnt_q;
    assign o_ld_err     = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a default-depth instance and a
// DEPTH_LOG2=3 instance for the overflow case.
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        imem_ready;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic [10:0] ld_count;
    logic        ld_err;

    logic        s_rst;
    logic [31:0] s_addr;
    logic [31:0] s_rdata;
    logic        s_imem_ready;
    logic        s_ld_valid;
    logic [31:0] s_ld_data;
    logic        s_ld_last;
    logic        s_ld_ready;
    logic [3:0]  s_ld_count;
    logic        s_ld_err;

    int n_checks;
    int n_fails;

    imem_responder #(.DEPTH_LOG2(10), .NOP_WORD(NOP)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_imem_addr  (addr),
        .o_imem_rdata (rdata),
        .o_imem_ready (imem_ready),
        .i_ld_valid   (ld_valid),
        .i_ld_data    (ld_data),
        .i_ld_last    (ld_last),
        .o_ld_ready   (ld_ready),
        .o_ld_count   (ld_count),
        .o_ld_err     (ld_err)
    );

    imem_responder #(.DEPTH_LOG2(3), .NOP_WORD(NOP)) u_dut_small (
        .i_clk        (clk),
        .i_rst        (s_rst),
        .i_imem_addr  (s_addr),
        .o_imem_rdata (s_rdata),
        .o_imem_ready (s_imem_ready),
        .i_ld_valid   (s_ld_valid),
        .i_ld_data    (s_ld_data),
        .i_ld_last    (s_ld_last),
        .o_ld_ready   (s_ld_ready),
        .o_ld_count   (s_ld_count),
        .o_ld_err     (s_ld_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_big(input int cycles);
        rst      = 1'b1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        addr       = 32'd0;
        ld_data    = 32'd0;
        s_addr     = 32'd0;
        s_ld_valid = 1'b0;
        s_ld_data  = 32'd0;
        s_ld_last  = 1'b0;
        s_rst      = 1'b1;

        // Reset state
        reset_big(2);
        s_rst = 1'b0;
        check("rst_ld_ready",   32'(ld_ready),   32'd1);
        check("rst_imem_ready", 32'(imem_ready), 32'd0);
        check("rst_rdata",      rdata,           NOP);
        check("rst_count",      32'(ld_count),   32'd0);
        check("rst_err",        32'(ld_err),     32'd0);

        // Short load and readback
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hAA00_0001 + 32'(i);
            ld_last  = (i == 3);
            if (i == 3) check("short_ready_before_last", 32'(imem_ready), 32'd0);
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("short_imem_ready", 32'(imem_ready), 32'd1);
        check("short_ld_ready",   32'(ld_ready),   32'd0);
        check("short_count",      32'(ld_count),   32'd4);
        check("short_err",        32'(ld_err),     32'd0);
        check("short_edge_nop",   rdata,           NOP);
        for (int i = 0; i < 4; i++) begin
            addr = 32'(i);
            step();
            check($sformatf("short_rd%0d", i), rdata, 32'hAA00_0001 + 32'(i));
        end

        // Gapped valid with read masking during LOAD
        reset_big(1);
        addr = 32'd0;
        for (int i = 0; i < 4; i++) begin
            ld_valid = (i % 2 == 0);
            ld_data  = (i == 0) ? 32'h1111_0000 : (i == 2) ? 32'h2222_0000 : 32'hDEAD_BEEF;
            step();
            check($sformatf("gap_rdata_nop%0d", i), rdata, NOP);
        end
        ld_valid = 1'b0;
        check("gap_count",      32'(ld_count),   32'd2);
        check("gap_imem_ready", 32'(imem_ready), 32'd0);
        ld_valid = 1'b1;
        ld_data  = 32'h3333_0000;
        ld_last  = 1'b1;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("gap_count3", 32'(ld_count), 32'd3);
        addr = 32'd1;
        step();
        check("gap_rd1", rdata, 32'h2222_0000);
        addr = 32'd2;
        step();
        check("gap_rd2", rdata, 32'h3333_0000);

        // Mid-run reset and one-word reload
        reset_big(1);
        check("mr_imem_ready_rst", 32'(imem_ready), 32'd0);
        check("mr_count_rst",      32'(ld_count),   32'd0);
        ld_valid = 1'b1;
        ld_data  = 32'h1234_5678;
        ld_last  = 1'b1;
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("mr_imem_ready", 32'(imem_ready), 32'd1);
        check("mr_count",      32'(ld_count),   32'd1);
        addr = 32'd0;
        step();
        check("mr_rd0", rdata, 32'h1234_5678);

        // Full 1024-word load, then range boundary reads
        reset_big(1);
        for (int i = 0; i < 1024; i++) begin
            ld_valid = 1'b1;
            ld_data  = 32'hC000_0000 | 32'(i);
            ld_last  = (i == 1023);
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("full_count", 32'(ld_count), 32'd1024);
        check("full_err",   32'(ld_err),   32'd0);
        addr = 32'h0000_0400;
        step();
        check("oor_400", rdata, NOP);
        addr = 32'h0000_03FF;
        step();
        check("rd_3ff", rdata, 32'hC000_03FF);
        addr = 32'hFFFF_FFFF;
        step();
        check("oor_ffff", rdata, NOP);

        // Overflow on the 8-word instance
        for (int i = 0; i < 9; i++) begin
            s_ld_valid = 1'b1;
            s_ld_data  = 32'hBB00_0000 + 32'(i);
            s_ld_last  = 1'b0;
            check($sformatf("ovf_ld_ready%0d", i), 32'(s_ld_ready), (i < 8) ? 32'd1 : 32'd0);
            step();
            if (i == 7) begin
                check("ovf_err",        32'(s_ld_err),     32'd1);
                check("ovf_imem_ready", 32'(s_imem_ready), 32'd1);
                check("ovf_count",      32'(s_ld_count),   32'd8);
            end
        end
        s_ld_valid = 1'b0;
        check("ovf_count_after9", 32'(s_ld_count), 32'd8);
        s_addr = 32'd0;
        step();
        check("ovf_rd0", s_rdata, 32'hBB00_0000);
        s_addr = 32'd7;
        step();
        check("ovf_rd7", s_rdata, 32'hBB00_0007);
        s_addr = 32'd8;
        step();
        check("ovf_oor8", s_rdata, NOP);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
